mem_control: RTL and testbench

Memory/IO controller directly downstream of the MEM stage. It turns the stage's per-instruction memory request (address, read/write enables, write data) into cycle-accurate strobes for the external 16-bit asynchronous SRAM and the memory-mapped UART. It returns read data to the stage and holds the pipeline stalled until a multi-cycle access completes.

---
 rtl/mem_control.sv | 165 ++++++++++++++++
 tb/tb_mem_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_control.sv
// Memory/IO controller between the MEM stage and the external async SRAM and UART.
// Sequences multi-cycle strobes and stalls the pipeline until each access completes.
module mem_control #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memAddr_i,
    input  logic        rMem_i,
    input  logic        wMem_i,
    input  logic [15:0] wData_mem_i,
    output logic [15:0] rData_o,
    output logic        stall_o,
    output logic [17:0] ram_addr_o,
    output logic [15:0] ram_data_o,
    output logic        ram_data_oe_o,
    input  logic [15:0] ram_data_i,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o,
    output logic [7:0]  uart_data_o,
    input  logic [7:0]  uart_data_i,
    output logic        uart_wrn_o,
    output logic        uart_rdn_o,
    input  logic        uart_tbre_i,
    input  logic        uart_tsre_i,
    input  logic        uart_data_ready_i
);

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned RAM_ADDR_W = 18;
    localparam int unsigned UART_W     = 8;

    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD,
        U_WSETUP, U_WPULSE, U_WDONE,
        U_RPULSE1, U_RPULSE2, U_RDONE
    } state_t;

    state_t                  state_q, state_d;
    logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [UART_W-1:0]       uart_q, uart_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    we_n_q, we_n_d;
    logic                    wrn_q, wrn_d;
    logic                    rdn_q, rdn_d;

    logic is_data, is_stat, req_w, req_r;

    // Reset masks requests so a request in the reset cycle never starts an access
    assign is_data = (memAddr_i == UART_DATA_ADDR);
    assign is_stat = (memAddr_i == UART_STAT_ADDR);
    assign req_w   = wMem_i & ~rst;
    assign req_r   = rMem_i & ~wMem_i & ~rst;

    assign ram_we_n_o  = we_n_q;
    assign uart_wrn_o  = wrn_q;
    assign uart_rdn_o  = rdn_q;
    assign ram_data_o  = wdata_q;
    assign uart_data_o = uart_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            uart_q  <= '0;
            rdata_q <= '0;
            we_n_q  <= 1'b1;
            wrn_q   <= 1'b1;
            rdn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            uart_q  <= uart_d;
            rdata_q <= rdata_d;
            we_n_q  <= we_n_d;
            wrn_q   <= wrn_d;
            rdn_q   <= rdn_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        uart_d        = uart_q;
        rdata_d       = rdata_q;
        rData_o       = '0;
        stall_o       = 1'b0;
        ram_ce_n_o    = 1'b1;
        ram_oe_n_o    = 1'b1;
        ram_data_oe_o = 1'b0;
        ram_addr_o    = RAM_ADDR_W'(memAddr_i);

        case (state_q)
            IDLE: begin
                if (req_w) begin
                    if (is_data) begin
                        uart_d  = wData_mem_i[UART_W-1:0];
                        stall_o = 1'b1;
                        state_d = U_WSETUP;
                    end else if (!is_stat) begin
                        addr_d  = RAM_ADDR_W'(memAddr_i);
                        wdata_d = wData_mem_i;
                        stall_o = 1'b1;
                        state_d = W_SETUP;
                    end
                end else if (req_r) begin
                    if (is_data) begin
                        stall_o = 1'b1;
                        state_d = U_RPULSE1;
                    end else if (is_stat) begin
                        rData_o = {{(DATA_W-2){1'b0}}, uart_data_ready_i,
                                   uart_tbre_i & uart_tsre_i};
                    end else begin
                        ram_ce_n_o = 1'b0;
                        ram_oe_n_o = 1'b0;
                        rData_o    = ram_data_i;
                    end
                end
            end
            W_SETUP, W_PULSE, W_HOLD: begin
                ram_ce_n_o    = 1'b0;
                ram_data_oe_o = 1'b1;
                ram_addr_o    = addr_q;
                stall_o       = (state_q != W_HOLD);
                state_d       = (state_q == W_SETUP) ? W_PULSE :
                                (state_q == W_PULSE) ? W_HOLD  : IDLE;
            end
            U_WSETUP: begin
                stall_o = 1'b1;
                state_d = U_WPULSE;
            end
            U_WPULSE: begin
                stall_o = 1'b1;
                state_d = U_WDONE;
            end
            U_WDONE: state_d = IDLE;
            U_RPULSE1: begin
                stall_o = 1'b1;
                state_d = U_RPULSE2;
            end
            U_RPULSE2: begin
                stall_o = 1'b1;
                rdata_d = {{(DATA_W-UART_W){1'b0}}, uart_data_i};
                state_d = U_RDONE;
            end
            U_RDONE: begin
                rData_o = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they change only on clock edges
        we_n_d = (state_d != W_PULSE);
        wrn_d  = (state_d != U_WPULSE);
        rdn_d  = !((state_d == U_RPULSE1) || (state_d == U_RPULSE2));
    end

endmodule

// File: tb/tb_mem_control.sv
// Bench for mem_control: directed and random instructions checked per cycle
// against a transaction-level model of expected stall/strobe timing and memory contents.
module tb_mem_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memAddr_i;
    logic        rMem_i, wMem_i;
    logic [15:0] wData_mem_i;
    logic [15:0] rData_o;
    logic        stall_o;
    logic [17:0] ram_addr_o;
    logic [15:0] ram_data_o;
    logic        ram_data_oe_o;
    logic [15:0] ram_data_i;
    logic        ram_ce_n_o, ram_oe_n_o, ram_we_n_o;
    logic [7:0]  uart_data_o, uart_data_i;
    logic        uart_wrn_o, uart_rdn_o;
    logic        uart_tbre_i, uart_tsre_i, uart_data_ready_i;

    int checks = 0;
    int errors = 0;

    localparam int K_NOP = 0, K_MW = 1, K_MR = 2, K_UW = 3, K_UR = 4, K_SR = 5, K_SW = 6;

    logic [15:0] ref_mem  [256];
    logic [15:0] sram_mem [256];
    logic [7:0]  written_q [$];

    mem_control dut (
        .clk(clk), .rst(rst),
        .memAddr_i(memAddr_i), .rMem_i(rMem_i), .wMem_i(wMem_i), .wData_mem_i(wData_mem_i),
        .rData_o(rData_o), .stall_o(stall_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_oe_o(ram_data_oe_o),
        .ram_data_i(ram_data_i),
        .ram_ce_n_o(ram_ce_n_o), .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o),
        .uart_data_o(uart_data_o), .uart_data_i(uart_data_i),
        .uart_wrn_o(uart_wrn_o), .uart_rdn_o(uart_rdn_o),
        .uart_tbre_i(uart_tbre_i), .uart_tsre_i(uart_tsre_i),
        .uart_data_ready_i(uart_data_ready_i)
    );

    always #5 clk = ~clk;

    // External SRAM: combinational read, write committed while we_n is low
    assign ram_data_i = (!ram_ce_n_o && !ram_oe_n_o) ? sram_mem[ram_addr_o[7:0]] : 16'hDEAD;
    always @(posedge clk)
        if (!rst && ram_we_n_o === 1'b0 && ram_ce_n_o === 1'b0 && ram_data_oe_o === 1'b1)
            sram_mem[ram_addr_o[7:0]] <= ram_data_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline instruction: expected timeline derived from the access type
    task automatic step_instr(input logic [15:0] a, input logic r, input logic w,
                              input logic [15:0] wd);
        int kind;
        int len;
        memAddr_i   = a;
        rMem_i      = r;
        wMem_i      = w;
        wData_mem_i = wd;
        if (w)      kind = (a == 16'hBF00) ? K_UW : (a == 16'hBF01) ? K_SW : K_MW;
        else if (r) kind = (a == 16'hBF00) ? K_UR : (a == 16'hBF01) ? K_SR : K_MR;
        else        kind = K_NOP;
        len = (kind == K_MW || kind == K_UW || kind == K_UR) ? 3 : 0;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            check("stall", 32'(stall_o), 32'(k < len));
            check("we_n", 32'(ram_we_n_o), 32'(!(kind == K_MW && k == 2)));
            check("wrn", 32'(uart_wrn_o), 32'(!(kind == K_UW && k == 2)));
            check("rdn", 32'(uart_rdn_o), 32'(!(kind == K_UR && (k == 1 || k == 2))));
            case (kind)
                K_MW: if (k >= 1) begin
                    check("mw_ce_n", 32'(ram_ce_n_o), 32'd0);
                    check("mw_oe_n", 32'(ram_oe_n_o), 32'd1);
                    check("mw_data_oe", 32'(ram_data_oe_o), 32'd1);
                    check("mw_addr", 32'(ram_addr_o), 32'(a));
                    check("mw_data", 32'(ram_data_o), 32'(wd));
                end
                K_MR: begin
                    check("mr_ce_n", 32'(ram_ce_n_o), 32'd0);
                    check("mr_oe_n", 32'(ram_oe_n_o), 32'd0);
                    check("mr_data_oe", 32'(ram_data_oe_o), 32'd0);
                    check("mr_addr", 32'(ram_addr_o), 32'(a));
                    check("mr_rdata", 32'(rData_o), 32'(ref_mem[a[7:0]]));
                end
                K_UW: begin
                    check("uw_ce_n", 32'(ram_ce_n_o), 32'd1);
                    if (k >= 1) check("uw_data", 32'(uart_data_o), 32'(wd[7:0]));
                end
                K_UR: begin
                    check("ur_ce_n", 32'(ram_ce_n_o), 32'd1);
                    if (k == 3) check("ur_rdata", 32'(rData_o), 32'(uart_data_i));
                end
                K_SR: begin
                    check("sr_ce_n", 32'(ram_ce_n_o), 32'd1);
                    check("sr_rdata", 32'(rData_o),
                          32'({uart_data_ready_i, uart_tbre_i & uart_tsre_i}));
                end
                default: begin
                    check("idle_ce_n", 32'(ram_ce_n_o), 32'd1);
                    check("idle_data_oe", 32'(ram_data_oe_o), 32'd0);
                    check("idle_rdata", 32'(rData_o), 32'd0);
                end
            endcase
            @(posedge clk);
            #1;
        end
        if (kind == K_MW) begin
            ref_mem[a[7:0]] = wd;
            written_q.push_back(a[7:0]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we_n"}, 32'(ram_we_n_o), 32'd1);
        check({tag, "_oe_n"}, 32'(ram_oe_n_o), 32'd1);
        check({tag, "_ce_n"}, 32'(ram_ce_n_o), 32'd1);
        check({tag, "_wrn"}, 32'(uart_wrn_o), 32'd1);
        check({tag, "_rdn"}, 32'(uart_rdn_o), 32'd1);
        check({tag, "_data_oe"}, 32'(ram_data_oe_o), 32'd0);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_rdata"}, 32'(rData_o), 32'd0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] a;
        int          kind;

        // Reset held two cycles with a write request present
        rst = 1'b1; rMem_i = 1'b0; wMem_i = 1'b1;
        memAddr_i = 16'h0010; wData_mem_i = 16'h5555;
        uart_data_i = 8'h00; uart_tbre_i = 1'b0; uart_tsre_i = 1'b0; uart_data_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_ram_data", 32'(ram_data_o), 32'd0);
        check("rst_uart_data", 32'(uart_data_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wMem_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        @(posedge clk); #1;

        // Directed test plan
        step_instr(16'h0040, 1'b0, 1'b1, 16'h1234);
        step_instr(16'h0040, 1'b1, 1'b0, 16'h0000);
        step_instr(16'hBF00, 1'b0, 1'b1, 16'h0041);
        uart_data_i = 8'h5A;
        step_instr(16'hBF00, 1'b1, 1'b0, 16'h0000);
        uart_tbre_i = 1'b1; uart_tsre_i = 1'b1; uart_data_ready_i = 1'b0;
        step_instr(16'hBF01, 1'b1, 1'b0, 16'h0000);
        uart_tbre_i = 1'b0; uart_tsre_i = 1'b0; uart_data_ready_i = 1'b1;
        step_instr(16'hBF01, 1'b1, 1'b0, 16'h0000);
        step_instr(16'hBF01, 1'b0, 1'b1, 16'hFFFF);
        step_instr(16'h0041, 1'b1, 1'b1, 16'hA5C3);
        step_instr(16'h0041, 1'b1, 1'b0, 16'h0000);

        // Reset while the write pulse is active abandons the access
        memAddr_i = 16'h0080; wMem_i = 1'b1; rMem_i = 1'b0; wData_mem_i = 16'hBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_we_low", 32'(ram_we_n_o), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0; wMem_i = 1'b0;
        step_instr(16'h0040, 1'b1, 1'b0, 16'h0000);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 6));
            uart_data_i       = 8'($urandom);
            uart_tbre_i       = 1'($urandom);
            uart_tsre_i       = 1'($urandom);
            uart_data_ready_i = 1'($urandom);
            b = 8'($urandom);
            case (kind)
                K_MW: step_instr({8'h00, b}, 1'($urandom), 1'b1, 16'($urandom));
                K_MR: begin
                    a = {8'h00, written_q[$urandom_range(0, written_q.size() - 1)]};
                    step_instr(a, 1'b1, 1'b0, 16'($urandom));
                end
                K_UW: step_instr(16'hBF00, 1'($urandom), 1'b1, 16'($urandom));
                K_UR: step_instr(16'hBF00, 1'b1, 1'b0, 16'($urandom));
                K_SR: step_instr(16'hBF01, 1'b1, 1'b0, 16'($urandom));
                K_SW: step_instr(16'hBF01, 1'($urandom), 1'b1, 16'($urandom));
                default: step_instr({8'h00, b}, 1'b0, 1'b0, 16'($urandom));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
